uart_baud_gen: RTL and testbench

//   Parametrised UART baud-tick generator. Successor to the fixed-divisor UART clock block.

---
 rtl/uart_baud_gen.sv | 97 +++++++++
 tb/tb_uart_baud_gen.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/uart_baud_gen.sv
// UART baud-tick generator: fractional clock divider producing oversample,
// mid-bit and bit-end ticks, with a runtime-loadable divisor and RX phase resync.
module uart_baud_gen #(
    parameter int DIV_W      = 16,
    parameter int FRAC_W     = 4,
    parameter int OVERSAMPLE = 16,
    parameter int DIV_RST    = 651,
    parameter int FRAC_RST   = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic                    resync,
    input  logic                    div_we,
    input  logic [DIV_W-1:0]        div_int,
    input  logic [FRAC_W-1:0]       div_frac,
    output logic                    tick_os,
    output logic                    tick_mid,
    output logic                    tick_bit,
    output logic [DIV_W+FRAC_W-1:0] div_cur
);

    localparam int OS_W = $clog2(OVERSAMPLE);
    localparam logic [OS_W-1:0]   MID_IDX  = OS_W'(OVERSAMPLE/2 - 1);
    localparam logic [OS_W-1:0]   LAST_IDX = OS_W'(OVERSAMPLE - 1);
    localparam logic [DIV_W-1:0]  INT_MIN  = DIV_W'(2);
    localparam logic [DIV_W-1:0]  INT_RST  = DIV_W'(DIV_RST);
    localparam logic [FRAC_W-1:0] FR_RST   = FRAC_W'(FRAC_RST);

    logic [DIV_W-1:0]  cnt;
    logic [DIV_W-1:0]  int_act, int_sh;
    logic [FRAC_W-1:0] frac_act, frac_sh;
    logic [FRAC_W-1:0] acc;
    logic              carry;
    logic [OS_W-1:0]   os_idx;

    logic [DIV_W-1:0]  int_eff;
    logic [DIV_W:0]    p_m1;
    logic [FRAC_W:0]   acc_sum;
    logic              wrap;

    // Period is clamped to at least 2 cycles; carry stretches it by one
    always_comb begin
        int_eff = (int_act < INT_MIN) ? INT_MIN : int_act;
        p_m1    = {1'b0, int_eff} + (DIV_W+1)'(carry) - (DIV_W+1)'(1);
        wrap    = ({1'b0, cnt} == p_m1);
        acc_sum = {1'b0, acc} + {1'b0, frac_act};
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt      <= '0;
            os_idx   <= '0;
            acc      <= '0;
            carry    <= 1'b0;
            int_act  <= INT_RST;
            frac_act <= FR_RST;
            int_sh   <= INT_RST;
            frac_sh  <= FR_RST;
            tick_os  <= 1'b0;
            tick_mid <= 1'b0;
            tick_bit <= 1'b0;
        end else begin
            tick_os  <= 1'b0;
            tick_mid <= 1'b0;
            tick_bit <= 1'b0;
            if (div_we) begin
                int_sh  <= div_int;
                frac_sh <= div_frac;
            end
            if (resync || !en) begin
                // Idle/restart: clear phase and apply any pending divisor right away
                cnt      <= '0;
                os_idx   <= '0;
                acc      <= '0;
                carry    <= 1'b0;
                int_act  <= div_we ? div_int  : int_sh;
                frac_act <= div_we ? div_frac : frac_sh;
            end else if (wrap) begin
                cnt           <= '0;
                tick_os       <= 1'b1;
                tick_mid      <= (os_idx == MID_IDX);
                tick_bit      <= (os_idx == LAST_IDX);
                {carry, acc}  <= acc_sum;
                os_idx        <= (os_idx == LAST_IDX) ? '0 : os_idx + OS_W'(1);
                // Old shadow is used, so a write on this very edge lands one period later
                int_act       <= int_sh;
                frac_act      <= frac_sh;
            end else begin
                cnt <= cnt + DIV_W'(1);
            end
        end
    end

    assign div_cur = {int_act, frac_act};

endmodule

// File: tb/tb_uart_baud_gen.sv
// Self-checking bench for uart_baud_gen: expected tick intervals are queued
// when stimulus is applied and compared as the DUT produces ticks.
module tb_uart_baud_gen;

    localparam int DIV_W  = 16;
    localparam int FRAC_W = 4;
    localparam int W      = DIV_W + FRAC_W;

    logic              clk = 1'b0;
    logic              rst;
    logic              en;
    logic              resync;
    logic              div_we;
    logic [DIV_W-1:0]  div_int;
    logic [FRAC_W-1:0] div_frac;
    logic              tick_os, tick_mid, tick_bit;
    logic [W-1:0]      div_cur;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int exp_q[$];

    uart_baud_gen #(
        .DIV_W(DIV_W), .FRAC_W(FRAC_W), .OVERSAMPLE(16), .DIV_RST(651), .FRAC_RST(0)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .resync(resync), .div_we(div_we),
        .div_int(div_int), .div_frac(div_frac), .tick_os(tick_os),
        .tick_mid(tick_mid), .tick_bit(tick_bit), .div_cur(div_cur)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // sel: 0 = tick_os, 1 = tick_mid, 2 = tick_bit; t = -1 on timeout
    task automatic wait_tick(input int sel, input int budget, output int t);
        t = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if ((sel == 0 && tick_os === 1'b1) || (sel == 1 && tick_mid === 1'b1) ||
                (sel == 2 && tick_bit === 1'b1)) begin
                t = cyc;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; en = 1'b0; resync = 1'b0; div_we = 1'b0; div_int = '0; div_frac = '0;
        repeat (3) @(negedge clk);
        total++; if (tick_os !== 1'b0) begin bad++; $display("FAIL reset_tick_os got=%b exp=0", tick_os); end
        total++; if (tick_mid !== 1'b0) begin bad++; $display("FAIL reset_tick_mid got=%b exp=0", tick_mid); end
        total++; if (tick_bit !== 1'b0) begin bad++; $display("FAIL reset_tick_bit got=%b exp=0", tick_bit); end
        total++; if (div_cur !== W'(651*16)) begin bad++; $display("FAIL reset_div_cur got=%0d exp=%0d", div_cur, 651*16); end
    endtask

    task automatic test_defaults();
        int t0, prev, t, e, tb;
        rst = 1'b1; en = 1'b1;
        t0 = cyc;
        exp_q.push_back(651); exp_q.push_back(651); exp_q.push_back(651);
        prev = t0;
        while (exp_q.size() > 0) begin
            wait_tick(0, 2000, t);
            e = exp_q.pop_front();
            total++; if (t - prev !== e) begin bad++; $display("FAIL default_os_period got=%0d exp=%0d", t - prev, e); end
            prev = t;
        end
        @(negedge clk);
        total++; if (tick_os !== 1'b0) begin bad++; $display("FAIL os_one_cycle got=%b exp=0", tick_os); end
        wait_tick(2, 11000, tb);
        total++; if (tb - t0 !== 10416) begin bad++; $display("FAIL first_bit got=%0d exp=10416", tb - t0); end
        wait_tick(1, 6000, t);
        total++; if (t - tb !== 5208) begin bad++; $display("FAIL mid_after_bit got=%0d exp=5208", t - tb); end
        wait_tick(2, 6000, t);
        total++; if (t - tb !== 10416) begin bad++; $display("FAIL bit_period got=%0d exp=10416", t - tb); end
    endtask

    task automatic test_frac();
        int prev, t, e, b1, b2;
        div_we = 1'b1; div_int = 16'd10; div_frac = 4'd8;
        @(negedge clk);
        div_we = 1'b0;
        total++; if (div_cur !== W'(651*16)) begin bad++; $display("FAIL frac_shadow_only got=%0d exp=%0d", div_cur, 651*16); end
        wait_tick(0, 700, prev);
        total++; if (div_cur !== W'(10*16+8)) begin bad++; $display("FAIL frac_div_cur got=%0d exp=%0d", div_cur, 10*16+8); end
        exp_q.push_back(10); exp_q.push_back(10); exp_q.push_back(11); exp_q.push_back(10);
        exp_q.push_back(11); exp_q.push_back(10); exp_q.push_back(11);
        while (exp_q.size() > 0) begin
            wait_tick(0, 100, t);
            e = exp_q.pop_front();
            total++; if (t - prev !== e) begin bad++; $display("FAIL frac_os_period got=%0d exp=%0d", t - prev, e); end
            prev = t;
        end
        wait_tick(2, 300, b1);
        wait_tick(2, 300, b2);
        total++; if (b2 - b1 !== 168) begin bad++; $display("FAIL frac_bit_period got=%0d exp=168", b2 - b1); end
    endtask

    task automatic test_clamp();
        int prev, t, e;
        en = 1'b0; div_we = 1'b1; div_int = 16'd0; div_frac = 4'd0;
        @(negedge clk);
        div_we = 1'b0;
        total++; if (div_cur !== W'(0)) begin bad++; $display("FAIL clamp_div_cur got=%0d exp=0", div_cur); end
        total++; if (tick_os !== 1'b0) begin bad++; $display("FAIL clamp_idle_tick got=%b exp=0", tick_os); end
        en = 1'b1;
        prev = cyc;
        repeat (4) exp_q.push_back(2);
        while (exp_q.size() > 0) begin
            wait_tick(0, 20, t);
            e = exp_q.pop_front();
            total++; if (t - prev !== e) begin bad++; $display("FAIL clamp_os_period got=%0d exp=%0d", t - prev, e); end
            prev = t;
        end
    endtask

    task automatic test_midwrite();
        int t0, prev, t, e;
        en = 1'b0; div_we = 1'b1; div_int = 16'd100; div_frac = 4'd0;
        @(negedge clk);
        div_we = 1'b0; en = 1'b1;
        t0 = cyc;
        wait_tick(0, 200, prev);
        total++; if (prev - t0 !== 100) begin bad++; $display("FAIL mw_first got=%0d exp=100", prev - t0); end
        repeat (40) @(negedge clk);
        div_we = 1'b1; div_int = 16'd20;
        exp_q.push_back(100); exp_q.push_back(20); exp_q.push_back(20);
        @(negedge clk);
        div_we = 1'b0;
        while (exp_q.size() > 0) begin
            wait_tick(0, 200, t);
            e = exp_q.pop_front();
            total++; if (t - prev !== e) begin bad++; $display("FAIL mw_os_period got=%0d exp=%0d", t - prev, e); end
            prev = t;
        end
    endtask

    task automatic test_resync();
        int t0, t1, tr, t;
        en = 1'b0; div_we = 1'b1; div_int = 16'd651; div_frac = 4'd0;
        @(negedge clk);
        div_we = 1'b0; en = 1'b1;
        t0 = cyc;
        wait_tick(0, 700, t1);
        total++; if (t1 - t0 !== 651) begin bad++; $display("FAIL rs_first got=%0d exp=651", t1 - t0); end
        repeat (300) @(negedge clk);
        resync = 1'b1;
        @(negedge clk);
        resync = 1'b0;
        tr = cyc;
        wait_tick(0, 700, t);
        total++; if (t - tr !== 651) begin bad++; $display("FAIL rs_os_after got=%0d exp=651", t - tr); end
        wait_tick(1, 6000, t);
        total++; if (t - tr !== 8*651) begin bad++; $display("FAIL rs_mid got=%0d exp=%0d", t - tr, 8*651); end
        wait_tick(2, 6000, t);
        total++; if (t - tr !== 16*651) begin bad++; $display("FAIL rs_bit got=%0d exp=%0d", t - tr, 16*651); end
    endtask

    task automatic test_rst_mid();
        int prev, t, e;
        en = 1'b0; div_we = 1'b1; div_int = 16'd50; div_frac = 4'd3;
        @(negedge clk);
        div_we = 1'b0; en = 1'b1;
        repeat (1000) @(negedge clk);
        rst = 1'b0; en = 1'b0;
        @(negedge clk);
        total++; if (tick_os !== 1'b0) begin bad++; $display("FAIL rm_tick_os got=%b exp=0", tick_os); end
        total++; if (tick_mid !== 1'b0) begin bad++; $display("FAIL rm_tick_mid got=%b exp=0", tick_mid); end
        total++; if (tick_bit !== 1'b0) begin bad++; $display("FAIL rm_tick_bit got=%b exp=0", tick_bit); end
        total++; if (div_cur !== W'(651*16)) begin bad++; $display("FAIL rm_div_cur got=%0d exp=%0d", div_cur, 651*16); end
        rst = 1'b1;
        @(negedge clk);
        en = 1'b1;
        prev = cyc;
        exp_q.push_back(651); exp_q.push_back(651);
        while (exp_q.size() > 0) begin
            wait_tick(0, 700, t);
            e = exp_q.pop_front();
            total++; if (t - prev !== e) begin bad++; $display("FAIL rm_os_period got=%0d exp=%0d", t - prev, e); end
            prev = t;
        end
    endtask

    initial begin
        rst = 1'b0; en = 1'b0; resync = 1'b0; div_we = 1'b0; div_int = '0; div_frac = '0;
        @(negedge clk);
        test_reset();
        test_defaults();
        test_frac();
        test_clamp();
        test_midwrite();
        test_resync();
        test_rst_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
